// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared widths, opcodes, ALU-op encoding and decoder for id_ex
// Contents:
//   DATA_W / INSTR_W / REG_AW / OPC_W  fixed datapath widths
//   OPC_*                              5-bit opcode values
//   alu_op_e                           ALU operation select
//   ctrl_t                             decoded control bundle
//   decode()                           opcode -> ctrl_t
package id_ex_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 16;
   localparam int REG_AW  = 3;
   localparam int OPC_W   = 5;

   localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01000;
   localparam logic [OPC_W-1:0] OPC_SUBI = 5'b01001;
   localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01010;
   localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01011;
   localparam logic [OPC_W-1:0] OPC_LDI  = 5'b01100;
   localparam logic [OPC_W-1:0] OPC_LDD  = 5'b01101;
   localparam logic [OPC_W-1:0] OPC_STD  = 5'b01110;
   localparam logic [OPC_W-1:0] OPC_ADD  = 5'b10000;
   localparam logic [OPC_W-1:0] OPC_SUB  = 5'b10001;
   localparam logic [OPC_W-1:0] OPC_AND  = 5'b10010;
   localparam logic [OPC_W-1:0] OPC_OR   = 5'b10011;
   localparam logic [OPC_W-1:0] OPC_EOR  = 5'b10110;
   localparam logic [OPC_W-1:0] OPC_NOT  = 5'b11100;
   localparam logic [OPC_W-1:0] OPC_SHL  = 5'b11101;
   localparam logic [OPC_W-1:0] OPC_SHR  = 5'b11110;

   typedef enum logic [3:0] {
      ALU_ZERO,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOT,
      ALU_SHL,
      ALU_SHR,
      ALU_PASS_B
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    src_imm;     // operand B comes from k instead of X[rs]
      logic    regwrite;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
   } ctrl_t;

   function automatic ctrl_t decode(input logic [OPC_W-1:0] opc);
      ctrl_t c;
      c = '{alu_op: ALU_ZERO, src_imm: 1'b0, regwrite: 1'b0,
            mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};
      case (opc)
         OPC_ADDI: begin c.alu_op = ALU_ADD;    c.src_imm = 1'b1; c.regwrite = 1'b1; end
         OPC_SUBI: begin c.alu_op = ALU_SUB;    c.src_imm = 1'b1; c.regwrite = 1'b1; end
         OPC_ANDI: begin c.alu_op = ALU_AND;    c.src_imm = 1'b1; c.regwrite = 1'b1; end
         OPC_ORI:  begin c.alu_op = ALU_OR;     c.src_imm = 1'b1; c.regwrite = 1'b1; end
         OPC_LDI:  begin c.alu_op = ALU_PASS_B; c.src_imm = 1'b1; c.regwrite = 1'b1; end
         OPC_LDD: begin
            c.alu_op     = ALU_PASS_B;
            c.src_imm    = 1'b1;
            c.regwrite   = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         OPC_STD: begin
            c.alu_op    = ALU_PASS_B;
            c.src_imm   = 1'b1;
            c.mem_write = 1'b1;
         end
         OPC_ADD: begin c.alu_op = ALU_ADD; c.regwrite = 1'b1; end
         OPC_SUB: begin c.alu_op = ALU_SUB; c.regwrite = 1'b1; end
         OPC_AND: begin c.alu_op = ALU_AND; c.regwrite = 1'b1; end
         OPC_OR:  begin c.alu_op = ALU_OR;  c.regwrite = 1'b1; end
         OPC_EOR: begin c.alu_op = ALU_XOR; c.regwrite = 1'b1; end
         OPC_NOT: begin c.alu_op = ALU_NOT; c.regwrite = 1'b1; end
         OPC_SHL: begin c.alu_op = ALU_SHL; c.regwrite = 1'b1; end
         OPC_SHR: begin c.alu_op = ALU_SHR; c.regwrite = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_ex_regfile.sv
// rtl/id_ex_regfile.sv - 8x8 register file, two combinational reads, one synchronous write
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all registers)
//   raddr_a/rdata_a read port A
//   raddr_b/rdata_b read port B
//   we/waddr/wdata  write port, applied at the rising edge
module id_ex_regfile
   import id_ex_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [2**REG_AW];

   // No read-during-write bypass: a read in the write cycle returns the old value.
   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/id_ex.sv
// rtl/id_ex.sv - combined decode/execute stage with registered ID/EX->MEM outputs
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   instruction_input                   [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] k
//   regwrite/write_addr/write_data      register-file write-back from a later stage
//   regwrite_out, mem_read_out,
//   mem_write_out, mem_to_reg_out       registered control
//   alu_result                          registered ALU result or memory address
//   write_data_to_memory                registered X[rd]
//   rd_address                          registered rd field
module id_ex
   import id_ex_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instruction_input,
   input  logic               regwrite,
   input  logic [REG_AW-1:0]  write_addr,
   input  logic [DATA_W-1:0]  write_data,
   output logic               regwrite_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic               mem_to_reg_out,
   output logic [DATA_W-1:0]  alu_result,
   output logic [DATA_W-1:0]  write_data_to_memory,
   output logic [REG_AW-1:0]  rd_address
);

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs;
   logic [DATA_W-1:0] k;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] reg_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_y;
   ctrl_t             ctrl;

   assign opc = instruction_input[15:11];
   assign rd  = instruction_input[10:8];
   assign rs  = instruction_input[7:5];
   assign k   = instruction_input[7:0];

   id_ex_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (rd),
      .rdata_a (op_a),
      .raddr_b (rs),
      .rdata_b (reg_b),
      .we      (regwrite),
      .waddr   (write_addr),
      .wdata   (write_data)
   );

   assign ctrl = decode(opc);
   assign op_b = ctrl.src_imm ? k : reg_b;

   always_comb begin
      alu_y = '0;
      case (ctrl.alu_op)
         ALU_ADD:    alu_y = op_a + op_b;
         ALU_SUB:    alu_y = op_a - op_b;
         ALU_AND:    alu_y = op_a & op_b;
         ALU_OR:     alu_y = op_a | op_b;
         ALU_XOR:    alu_y = op_a ^ op_b;
         ALU_NOT:    alu_y = ~op_a;
         ALU_SHL:    alu_y = {op_a[DATA_W-2:0], 1'b0};
         ALU_SHR:    alu_y = {1'b0, op_a[DATA_W-1:1]};
         ALU_PASS_B: alu_y = op_b;
         default:    alu_y = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_out         <= 1'b0;
         mem_read_out         <= 1'b0;
         mem_write_out        <= 1'b0;
         mem_to_reg_out       <= 1'b0;
         alu_result           <= '0;
         write_data_to_memory <= '0;
         rd_address           <= '0;
      end else begin
         regwrite_out         <= ctrl.regwrite;
         mem_read_out         <= ctrl.mem_read;
         mem_write_out        <= ctrl.mem_write;
         mem_to_reg_out       <= ctrl.mem_to_reg;
         alu_result           <= alu_y;
         write_data_to_memory <= op_a;
         rd_address           <= rd;
      end
   end

endmodule

// File: tb/tb_id_ex.sv
// tb/tb_id_ex.sv - directed self-checking bench for id_ex
module tb_id_ex;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instruction_input;
   logic        regwrite;
   logic [2:0]  write_addr;
   logic [7:0]  write_data;
   logic        regwrite_out;
   logic        mem_read_out;
   logic        mem_write_out;
   logic        mem_to_reg_out;
   logic [7:0]  alu_result;
   logic [7:0]  write_data_to_memory;
   logic [2:0]  rd_address;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex dut (
      .clk                  (clk),
      .rst                  (rst),
      .instruction_input    (instruction_input),
      .regwrite             (regwrite),
      .write_addr           (write_addr),
      .write_data           (write_data),
      .regwrite_out         (regwrite_out),
      .mem_read_out         (mem_read_out),
      .mem_write_out        (mem_write_out),
      .mem_to_reg_out       (mem_to_reg_out),
      .alu_result           (alu_result),
      .write_data_to_memory (write_data_to_memory),
      .rd_address           (rd_address)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [4:0] opc, input logic [2:0] rd,
                                      input logic [7:0] low);
      return {opc, rd, low};
   endfunction

   // rs in bits [7:5]
   function automatic logic [7:0] rsf(input logic [2:0] rs);
      return {rs, 5'b0};
   endfunction

   // Drive one instruction (and optional write-back) for one edge, then sample after it.
   task automatic step(input logic [15:0] ins, input logic we, input logic [2:0] wa,
                       input logic [7:0] wd);
      @(negedge clk);
      instruction_input = ins;
      regwrite          = we;
      write_addr        = wa;
      write_data        = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input int rw, input int mr, input int mw,
                             input int m2r);
      check({tag, ".regwrite"},   regwrite_out,   rw);
      check({tag, ".mem_read"},   mem_read_out,   mr);
      check({tag, ".mem_write"},  mem_write_out,  mw);
      check({tag, ".mem_to_reg"}, mem_to_reg_out, m2r);
   endtask

   initial begin
      rst = 1'b1;
      instruction_input = mk(5'b10000, 3'd1, rsf(3'd1));
      regwrite = 1'b0; write_addr = '0; write_data = '0;

      // reset
      step(mk(5'b01100, 3'd3, 8'd77), 1'b1, 3'd3, 8'd77);
      check_ctrl("rst", 0, 0, 0, 0);
      check("rst.alu", alu_result, 0);
      check("rst.wdm", write_data_to_memory, 0);
      check("rst.rd", rd_address, 0);
      rst = 1'b0;

      step(mk(5'b10000, 3'd1, rsf(3'd1)), 1'b0, 3'd0, 8'd0);
      check("add_after_rst.alu", alu_result, 0);

      // load / R2 chain
      step(mk(5'b01100, 3'd1, 8'd51), 1'b1, 3'd1, 8'd51);
      check("ldi1.alu", alu_result, 51);
      check("ldi1.rw", regwrite_out, 1);
      check("ldi1.rd", rd_address, 1);
      step(mk(5'b01100, 3'd2, 8'd1), 1'b1, 3'd2, 8'd1);
      check("ldi2.alu", alu_result, 1);
      step(mk(5'b10000, 3'd2, rsf(3'd1)), 1'b1, 3'd2, 8'd52);
      check("add.alu", alu_result, 52);
      check("add.rd", rd_address, 2);
      step(mk(5'b10001, 3'd2, rsf(3'd1)), 1'b1, 3'd2, 8'd1);
      check("sub.alu", alu_result, 1);
      check("sub.rw", regwrite_out, 1);
      step(mk(5'b10010, 3'd2, rsf(3'd1)), 1'b1, 3'd2, 8'd1);
      check("and.alu", alu_result, 1);
      step(mk(5'b10011, 3'd2, rsf(3'd1)), 1'b1, 3'd2, 8'd51);
      check("or.alu", alu_result, 51);
      step(mk(5'b10110, 3'd2, rsf(3'd1)), 1'b0, 3'd0, 8'd0);
      check("eor.alu", alu_result, 0);
      check("eor.rd", rd_address, 2);
      check("eor.rw", regwrite_out, 1);

      // memory ops
      step(mk(5'b01110, 3'd1, 8'd1), 1'b0, 3'd0, 8'd0);
      check_ctrl("std", 0, 0, 1, 0);
      check("std.alu", alu_result, 1);
      check("std.wdm", write_data_to_memory, 51);
      step(mk(5'b01101, 3'd4, 8'd2), 1'b1, 3'd3, 8'd35);
      check_ctrl("ldd", 1, 1, 0, 1);
      check("ldd.alu", alu_result, 2);
      check("ldd.rd", rd_address, 4);

      // I-type
      step(mk(5'b01100, 3'd4, 8'd6), 1'b1, 3'd4, 8'd6);
      check("ldi4.alu", alu_result, 6);
      step(mk(5'b01000, 3'd3, 8'd1), 1'b1, 3'd3, 8'd36);
      check("addi.alu", alu_result, 36);
      step(mk(5'b01001, 3'd4, 8'd1), 1'b1, 3'd4, 8'd5);
      check("subi.alu", alu_result, 5);
      step(mk(5'b01010, 3'd3, 8'd1), 1'b1, 3'd3, 8'd35);
      check("andi36.alu", alu_result, 0);
      step(mk(5'b01010, 3'd3, 8'd1), 1'b0, 3'd0, 8'd0);
      check("andi35.alu", alu_result, 1);
      step(mk(5'b01011, 3'd4, 8'd6), 1'b1, 3'd2, 8'd2);
      check("ori.alu", alu_result, 7);
      check_ctrl("ori", 1, 0, 0, 0);

      // R1 type
      step(mk(5'b11100, 3'd1, 8'd0), 1'b1, 3'd3, 8'd2);
      check("not.alu", alu_result, 204);
      step(mk(5'b11101, 3'd2, 8'd0), 1'b1, 3'd5, 8'h80);
      check("shl.alu", alu_result, 4);
      step(mk(5'b11110, 3'd3, 8'd0), 1'b1, 3'd6, 8'h01);
      check("shr.alu", alu_result, 1);
      step(mk(5'b11101, 3'd5, 8'd0), 1'b0, 3'd0, 8'd0);
      check("shl80.alu", alu_result, 0);
      step(mk(5'b11110, 3'd6, 8'd0), 1'b0, 3'd0, 8'd0);
      check("shr01.alu", alu_result, 0);

      // same-edge write: old value seen, new value visible next instruction
      step(mk(5'b10000, 3'd1, rsf(3'd1)), 1'b1, 3'd1, 8'd10);
      check("haz_old.alu", alu_result, 102);
      step(mk(5'b10000, 3'd1, rsf(3'd1)), 1'b0, 3'd0, 8'd0);
      check("haz_new.alu", alu_result, 20);

      // undefined opcodes
      step(mk(5'b00000, 3'd1, 8'hFF), 1'b0, 3'd0, 8'd0);
      check_ctrl("nop0", 0, 0, 0, 0);
      check("nop0.alu", alu_result, 0);
      check("nop0.wdm", write_data_to_memory, 10);
      check("nop0.rd", rd_address, 1);
      step(mk(5'b11111, 3'd2, 8'h0F), 1'b0, 3'd0, 8'd0);
      check_ctrl("nop1f", 0, 0, 0, 0);
      check("nop1f.alu", alu_result, 0);

      // reset mid-stream beats a concurrent write and clears the register file
      rst = 1'b1;
      step(mk(5'b01100, 3'd1, 8'd99), 1'b1, 3'd1, 8'd99);
      check_ctrl("rst2", 0, 0, 0, 0);
      check("rst2.alu", alu_result, 0);
      check("rst2.rd", rd_address, 0);
      rst = 1'b0;
      step(mk(5'b10000, 3'd1, rsf(3'd1)), 1'b0, 3'd0, 8'd0);
      check("rst2_add.alu", alu_result, 0);
      check("rst2_add.wdm", write_data_to_memory, 0);
      step(mk(5'b10000, 3'd5, rsf(3'd2)), 1'b0, 3'd0, 8'd0);
      check("rst2_add52.alu", alu_result, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex.md
# id_ex

Combined instruction-decode / execute stage of the 8-bit RISC pipeline. It takes a 16-bit instruction and decodes it into memory and write-back control signals. It reads operands from an internal 8×8-bit register file and computes an 8-bit ALU result. Everything is presented on a registered ID/EX→MEM boundary. Write-back into the register file is driven externally from the later stage.

## Interface
Parameters: none (widths fixed: data 8, instruction 16, register address 3).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instruction_input  in  16  instruction: [15:11] opcode, [10:8] rd, [7:5] rs, [7:0] k/address
- regwrite  in  1  write-back enable for register file
- write_addr  in  3  write-back register index
- write_data  in  8  write-back data
- regwrite_out  out  1  registered: instruction writes rd
- mem_read_out  out  1  registered: data-memory read (LDD)
- mem_write_out  out  1  registered: data-memory write (STD)
- mem_to_reg_out  out  1  registered: write-back selects memory data
- alu_result  out  8  registered ALU result or memory address
- write_data_to_memory  out  8  registered X[rd] (store data)
- rd_address  out  3  registered instruction[10:8]

## Operation
- Register file: X[0..7], 8 bits each. All eight are ordinary registers, including X[0]. Reads are combinational. At the rising edge, when regwrite=1, X[write_addr] is set to write_data.
- Operands: A = X[instr[10:8]], B = X[instr[7:5]], k = instr[7:0].
- Opcodes and their effects (ctrl = regwrite/mem_read/mem_write/mem_to_reg):
  - ADDI 01000: A+k, ctrl 1000
  - SUBI 01001: A−k, ctrl 1000
  - ANDI 01010: A&k, ctrl 1000
  - ORI 01011: A|k, ctrl 1000
  - LDI 01100: k, ctrl 1000
  - LDD 01101: result=k (address), ctrl 1101
  - STD 01110: result=k (address), ctrl 0010; the store data is A (the register in field [10:8])
  - ADD 10000: A+B; SUB 10001: A−B; AND 10010: A&B; OR 10011: A|B; EOR 10110: A^B; all ctrl 1000
  - NOT 11100: ~A; SHL 11101: A<<1, zero fill; SHR 11110: A>>1, logical; all ctrl 1000
  - Any other opcode: NOP, result 0, ctrl 0000.
- Arithmetic is modulo 256. There is no carry or flag output.
- write_data_to_memory = A for every opcode. rd_address = instr[10:8] for every opcode.

## Timing
- Decode and ALU are combinational. All seven outputs are captured at the rising edge, giving one-cycle latency from instruction_input.
- Same-edge write and read: the pipeline register samples pre-write register values. There is no internal bypass, so a write at edge N is visible to an instruction sampled at edge N+1.
- Reset (rst=1 at an edge): X[0..7] and all outputs go to 0. Reset has priority over regwrite. Reset mid-stream discards the instruction present in that cycle.

## Structure
- Shared package: opcode localparams (the 15 values above), ALU-op encoding, widths (DATA_W=8, REG_AW=3).
- Sub-module id_ex_regfile: 8×8 registers, 2 combinational read ports, 1 synchronous write port, synchronous reset.
- The decoder, ALU and output register stay in the top.

## Test plan
- Reset: rst high for one edge → all outputs 0. A subsequent ADD 10000_001_001 yields alu_result 0.
- Load/ALU R2 chain:
  - LDI X1=51 (write-back 51→X1) gives alu 51, regwrite_out 1, rd 1.
  - LDI X2=1 gives alu 1.
  - ADD 10000_010_001 gives 52 (with write-back 52→X2).
  - SUB gives 1; AND gives 1; OR gives 51; EOR gives 0. Each has regwrite_out=1 and rd_address=2.
- Memory ops:
  - STD 01110_001_00000001 with X1=51 gives mem_write_out 1, regwrite_out 0, alu 1, write_data_to_memory 51.
  - LDD 01101_100_00000010 gives mem_read_out 1, mem_to_reg_out 1, regwrite_out 1, alu 2.
- I-type:
  - With X3=35 and X4=6: ADDI X3,1 gives 36; SUBI X4,1 gives 5.
  - ANDI with X3=36, k=1 gives 0; with X3=35 and k=1 it gives 1.
  - ORI with X4=5, k=6 gives 7.
- R1 type: X1=51 with NOT gives 204. X2=2 with SHL gives 4. X3=2 with SHR gives 1. X=0x80 with SHL gives 0; X=0x01 with SHR gives 0.
- Hazard/NOP:
  - An instruction reading a register being written in the same cycle sees the old value.
  - An undefined opcode (e.g. 00000) gives all ctrl 0 and alu 0.
  - Reset asserted mid-sequence clears the register file, so LDI-free ADD then yields 0.
